clarke_pipe: RTL and testbench

//  Parametrised, pipelined Clarke (abc -> alpha/beta) transform for the FOC current path.

---
 rtl/clarke_pipe.sv | 188 ++++++++++++++++++
 tb/tb_clarke_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clarke_pipe.sv
// Pipelined Clarke transform (abc -> alpha/beta) with valid/ready flow control,
// per-sample 2/3-phase mode, round-half-up, output saturation and sticky overflow flag.
module clarke_pipe #(
    parameter int DW   = 16,
    parameter int FRAC = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode_2ph,
    input  logic [DW-1:0] ia,
    input  logic [DW-1:0] ib,
    input  logic [DW-1:0] ic,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alpha,
    output logic [DW-1:0] beta,
    input  logic          sat_clr,
    output logic          sat_flag
);

    // round(2^frac / 3)
    function automatic int k3_calc(input int frac);
        longint p;
        p = longint'(1) << frac;
        return int'((p + 64'sd1) / 64'sd3);
    endfunction

    // round(2^frac / sqrt3): largest k with 3*(2k-1)^2 <= 4^(frac+1), found bit by bit
    function automatic int ks_calc(input int frac);
        longint lim;
        longint k;
        longint t;
        lim = longint'(1) << (2 * frac + 2);
        k   = 0;
        for (int b = frac; b >= 0; b--) begin
            t = k | (longint'(1) << b);
            if (64'sd3 * (64'sd2 * t - 64'sd1) * (64'sd2 * t - 64'sd1) <= lim) begin
                k = t;
            end
        end
        return int'(k);
    endfunction

    localparam int SW = DW + 2;
    localparam int KW = FRAC + 2;
    localparam int PW = SW + KW;
    localparam int K3 = k3_calc(FRAC);
    localparam int KS = ks_calc(FRAC);

    localparam logic signed [PW-1:0] K3_P  = PW'(K3);
    localparam logic signed [PW-1:0] KS_P  = PW'(KS);
    localparam logic signed [PW-1:0] HALF  = PW'(longint'(1) << (FRAC - 1));
    localparam logic signed [PW-1:0] MAX_P = PW'((longint'(1) << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_P = PW'(-(longint'(1) << (DW - 1)));
    localparam logic [DW-1:0]        MAX_D = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        MIN_D = {1'b1, {(DW-1){1'b0}}};

    // Returns {clamped, value}; the shift on the biased product is arithmetic.
    function automatic logic [DW:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] biased;
        logic signed [PW-1:0] shifted;
        logic [DW:0]          res;
        biased  = p + HALF;
        shifted = biased >>> FRAC;
        if (shifted > MAX_P) begin
            res = {1'b1, MAX_D};
        end else if (shifted < MIN_P) begin
            res = {1'b1, MIN_D};
        end else begin
            res = {1'b0, shifted[DW-1:0]};
        end
        return res;
    endfunction

    logic                 en;
    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    logic                 ov_q, ov_d;
    logic signed [SW-1:0] sa_q, sa_d, sb_q, sb_d;
    logic signed [PW-1:0] pa_q, pa_d, pb_q, pb_d;
    logic [DW-1:0]        alpha_q, alpha_d, beta_q, beta_d;
    logic                 sat_q, sat_d;
    logic                 sat_set;

    logic signed [SW-1:0] a_x, b_x, c_x;
    logic signed [SW-1:0] sa_c, sb_c;
    logic signed [PW-1:0] sa_ext, sb_ext;
    logic signed [PW-1:0] pa_c, pb_c;
    logic [DW:0]          ra, rb;

    assign en        = !ov_q || out_ready;
    assign in_ready  = en;
    assign out_valid = ov_q;
    assign alpha     = alpha_q;
    assign beta      = beta_q;
    assign sat_flag  = sat_q;

    // Two guard bits make every S1 sum exact.
    always_comb begin
        a_x = {{2{ia[DW-1]}}, ia};
        b_x = {{2{ib[DW-1]}}, ib};
        c_x = {{2{ic[DW-1]}}, ic};
        if (mode_2ph) begin
            sa_c = a_x + a_x + a_x;
            sb_c = a_x + b_x + b_x;
        end else begin
            sa_c = a_x + a_x - b_x - c_x;
            sb_c = b_x - c_x;
        end
    end

    always_comb begin
        sa_ext = {{KW{sa_q[SW-1]}}, sa_q};
        sb_ext = {{KW{sb_q[SW-1]}}, sb_q};
        pa_c   = sa_ext * K3_P;
        pb_c   = sb_ext * KS_P;
        ra     = round_sat(pa_q);
        rb     = round_sat(pb_q);
    end

    // A stalled pipeline holds everything; data registers only load behind valid data.
    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        ov_d    = ov_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        sat_set = 1'b0;
        if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
            ov_d = v2_q;
            if (in_valid) begin
                sa_d = sa_c;
                sb_d = sb_c;
            end
            if (v1_q) begin
                pa_d = pa_c;
                pb_d = pb_c;
            end
            if (v2_q) begin
                alpha_d = ra[DW-1:0];
                beta_d  = rb[DW-1:0];
                sat_set = ra[DW] | rb[DW];
            end
        end
        if (sat_set) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            ov_q    <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            ov_q    <= ov_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_clarke_pipe.sv
// Bench for clarke_pipe: directed cases with literal results plus a long randomized
// valid/ready run checked against an integer model of the transform.
module tb_clarke_pipe;

    localparam int DW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          mode_2ph  = 1'b0;
    logic [DW-1:0] ia        = '0;
    logic [DW-1:0] ib        = '0;
    logic [DW-1:0] ic        = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] alpha;
    logic [DW-1:0] beta;
    logic          sat_clr   = 1'b0;
    logic          sat_flag;

    clarke_pipe #(.DW(16), .FRAC(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode_2ph (mode_2ph),
        .ia       (ia),
        .ib       (ib),
        .ic       (ic),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alpha    (alpha),
        .beta     (beta),
        .sat_clr  (sat_clr),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic [32:0] exp_q[$];   // {saturated, alpha, beta}
    logic        mon_stall = 1'b0;
    logic        mon_clr   = 1'b0;
    logic        exp_flag  = 1'b0;
    logic [31:0] held      = '0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint x, input longint y);
        longint q;
        q = x / y;
        if (x < 0 && (x % y) != 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [32:0] model(input logic m, input logic [15:0] a, b, c);
        longint la, lb, lc, sa, sb, ra, rb;
        logic   sat;
        sat = 1'b0;
        la  = longint'($signed(a));
        lb  = longint'($signed(b));
        lc  = longint'($signed(c));
        if (m) begin
            sa = 3 * la;
            sb = la + 2 * lb;
        end else begin
            sa = 2 * la - lb - lc;
            sb = lb - lc;
        end
        ra = floor_div(sa * 10923 + 16384, 32768);
        rb = floor_div(sb * 18919 + 16384, 32768);
        if (ra > 32767)  begin ra = 32767;  sat = 1'b1; end
        if (ra < -32768) begin ra = -32768; sat = 1'b1; end
        if (rb > 32767)  begin rb = 32767;  sat = 1'b1; end
        if (rb < -32768) begin rb = -32768; sat = 1'b1; end
        return {sat, ra[15:0], rb[15:0]};
    endfunction

    // Compare process: looks at the handshake that the coming rising edge will perform.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        set_now;
        if (!rst_n) begin
            exp_q.delete();
            mon_stall = 1'b0;
            mon_clr   = 1'b0;
            exp_flag  = 1'b0;
        end else begin
            set_now = 1'b0;
            check("in_ready", in_ready, !out_valid || out_ready);
            if (mon_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {alpha, beta}, held);
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got alpha %0d beta %0d, expected no output",
                             $signed(alpha), $signed(beta));
                end else begin
                    e = exp_q[0];
                    check("alpha", $signed(alpha), $signed(e[31:16]));
                    check("beta", $signed(beta), $signed(e[15:0]));
                    set_now = e[32];
                end
            end
            if (set_now) exp_flag = 1'b1;
            else if (mon_clr) exp_flag = 1'b0;
            check("sat_flag", sat_flag, exp_flag);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            mon_stall = out_valid && !out_ready;
            held      = {alpha, beta};
            if (in_valid && in_ready) exp_q.push_back(model(mode_2ph, ia, ib, ic));
            mon_clr = sat_clr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic m, input int a, input int b, input int c);
        in_valid = v;
        mode_2ph = m;
        ia       = a[15:0];
        ib       = b[15:0];
        ic       = c[15:0];
    endtask

    task automatic send(input logic m, input int a, input int b, input int c);
        logic ok;
        ok = 1'b0;
        set_in(1'b1, m, a, b, c);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_valid && in_ready;
            step();
        end
        check("send_accept", ok, 1);
        in_valid = 1'b0;
    endtask

    function automatic int rand_val();
        int v;
        case ($urandom_range(3))
            0:       v = 32767;
            1:       v = -32768;
            default: v = int'($urandom_range(65535)) - 32768;
        endcase
        return v;
    endfunction

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 100) begin
            step();
            i++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [32:0] m;
        int          base, acc, cyc;
        logic        pend, ok;

        // Reset state and model pins
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_alpha", alpha, 0);
        check("rst_beta", beta, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_in_ready", in_ready, 1);
        m = model(1'b0, 16'd1000, 16'hFE0C, 16'hFE0C);
        check("model_t1", m, {1'b0, 16'd1000, 16'd0});
        m = model(1'b0, 16'd0, 16'd1000, 16'hFC18);
        check("model_t2", m, {1'b0, 16'd0, 16'd1155});
        m = model(1'b0, 16'h7FFF, 16'h8000, 16'h8000);
        check("model_t3", m, {1'b1, 16'h7FFF, 16'd0});
        rst_n = 1'b1;
        step();

        // 3-phase balanced sample, exact latency
        set_in(1'b1, 1'b0, 1000, -500, -500);
        step();
        set_in(1'b0, 1'b0, 0, 0, 0);
        step();
        check("t1_not_yet", out_valid, 0);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_alpha", $signed(alpha), 1000);
        check("t1_beta", $signed(beta), 0);
        check("t1_sat", sat_flag, 0);
        step();

        // Mode switch back to back
        set_in(1'b1, 1'b0, 0, 1000, -1000);
        step();
        set_in(1'b1, 1'b1, 1000, -500, 0);
        step();
        set_in(1'b0, 1'b0, 0, 0, 0);
        step();
        check("t2a_valid", out_valid, 1);
        check("t2a_alpha", $signed(alpha), 0);
        check("t2a_beta", $signed(beta), 1155);
        step();
        check("t2b_valid", out_valid, 1);
        check("t2b_alpha", $signed(alpha), 1000);
        check("t2b_beta", $signed(beta), 0);
        step();

        // Saturation, clear, and clear colliding with a saturating update
        set_in(1'b1, 1'b0, 32767, -32768, -32768);
        step();
        set_in(1'b0, 1'b0, 0, 0, 0);
        step();
        step();
        check("t3_alpha", $signed(alpha), 32767);
        check("t3_beta", $signed(beta), 0);
        check("t3_sat_set", sat_flag, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("t3_sat_clr", sat_flag, 0);
        set_in(1'b1, 1'b0, 32767, -32768, -32768);
        step();
        set_in(1'b0, 1'b0, 0, 0, 0);
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("t3_set_wins", sat_flag, 1);
        check("t3_alpha2", $signed(alpha), 32767);
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;

        // Stream of 8 with a 4-cycle downstream stall
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(1'($urandom_range(1)), rand_val(), rand_val(), rand_val());
                end
            end
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (4) begin
                    step();
                    check("t4_stall_in_ready", in_ready, 0);
                    check("t4_stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
        join
        drain("t4_drain");
        check("t4_count", n_out - base, 8);

        // Reset with samples in flight
        send(1'b0, 1000, -500, -500);
        send(1'b1, -700, 300, 0);
        send(1'b0, 20000, -100, 5);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_alpha", alpha, 0);
        check("t5_rst_beta", beta, 0);
        step();
        rst_n = 1'b1;
        repeat (6) begin
            step();
            check("t5_no_stale", out_valid, 0);
        end
        set_in(1'b1, 1'b0, 1000, -500, -500);
        step();
        set_in(1'b0, 1'b0, 0, 0, 0);
        step();
        check("t5_not_yet", out_valid, 0);
        step();
        check("t5_valid", out_valid, 1);
        check("t5_alpha", $signed(alpha), 1000);
        step();

        // Randomized traffic
        acc  = 0;
        cyc  = 0;
        pend = 1'b0;
        while (acc < 10000 && cyc < 80000) begin
            if (!pend) begin
                if ($urandom_range(3) != 0) begin
                    set_in(1'b1, 1'($urandom_range(1)), rand_val(), rand_val(), rand_val());
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(3) != 0);
            sat_clr   = ($urandom_range(15) == 0);
            @(negedge clk);
            ok = in_valid && in_ready;
            step();
            cyc++;
            if (ok) begin
                acc++;
                pend = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        check("t6_accepted", acc, 10000);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
